// File: rtl/light_ctrl_pkg.sv
// Shared types and defaults for the push_btn/light requester.
package light_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_OFF, FIRE} drv_state_t;

  localparam int unsigned DB_DEFAULT = 4;
  localparam int unsigned CW_DEFAULT = 8;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stable-count debouncer and rising-edge detect for a raw button.
module btn_debounce #(
  parameter int unsigned DB = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_btn,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DB + 1);

  logic             sync0;
  logic             sync1;
  logic             btn_prev;
  logic [CNT_W-1:0] cnt;

  // level only follows sync1 after DB consecutive disagreeing samples
  always_ff @(posedge clock) begin
    if (reset) begin
      sync0    <= 1'b0;
      sync1    <= 1'b0;
      level    <= 1'b0;
      btn_prev <= 1'b0;
      cnt      <= '0;
    end else begin
      sync0    <= raw_btn;
      sync1    <= sync0;
      btn_prev <= level;
      if (sync1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DB - 1)) begin
        level <= sync1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign press = level & ~btn_prev;

endmodule

// File: rtl/push_btn_driver.sv
// Requester for the light controller: debounced presses become single push_btn pulses.
// Optional acknowledge checker driving no_ack is built when PUSH_ACK_CHECK_EN is defined.
module push_btn_driver
  import light_ctrl_pkg::*;
#(
  parameter int unsigned DB = DB_DEFAULT,
  parameter int unsigned CW = CW_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          raw_btn,
  input  logic          light,
  output logic          push_btn,
  output logic          pending,
  output logic [CW-1:0] press_count,
  output logic          no_ack
);

  drv_state_t state;
  logic       press;
  logic       level_unused;

  btn_debounce #(.DB(DB)) u_debounce (
    .clock   (clock),
    .reset   (reset),
    .raw_btn (raw_btn),
    .level   (level_unused),
    .press   (press)
  );

  // Request FSM; push_btn/pending are registered alongside the state they decode
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      push_btn <= 1'b0;
      pending  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (press && !light) begin
            state    <= FIRE;
            push_btn <= 1'b1;
          end else if (press) begin
            state   <= WAIT_OFF;
            pending <= 1'b1;
          end
        end
        WAIT_OFF: begin
          if (!light) begin
            state    <= FIRE;
            pending  <= 1'b0;
            push_btn <= 1'b1;
          end
        end
        FIRE: begin
          state    <= IDLE;
          push_btn <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          push_btn <= 1'b0;
          pending  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of every accepted press, independent of FSM state
  always_ff @(posedge clock) begin
    if (reset) begin
      press_count <= '0;
    end else if (press && (press_count != {CW{1'b1}})) begin
      press_count <= press_count + CW'(1);
    end
  end

`ifdef PUSH_ACK_CHECK_EN
  logic [1:0] ack_win;

  // light must be seen in one of the two cycles after each pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      ack_win <= 2'd0;
      no_ack  <= 1'b0;
    end else if (push_btn) begin
      ack_win <= 2'd2;
    end else if (ack_win != 2'd0) begin
      if (light) begin
        ack_win <= 2'd0;
      end else begin
        ack_win <= ack_win - 2'd1;
        if (ack_win == 2'd1) begin
          no_ack <= 1'b1;
        end
      end
    end
  end
`else
  assign no_ack = 1'b0;
`endif

endmodule

// File: doc/push_btn_driver.md
Name: push_btn_driver

Overview:
- Requester side of the push_btn/light interface: drives the light controller's push_btn input and monitors its light output.
- Synchronises and debounces a raw mechanical button, and turns each clean press into a single-cycle push_btn pulse.
- A press made while light is ON is held pending and fires once light goes OFF.
- Also keeps a saturating count of accepted presses.

Parameters:
- DB, 4, consecutive stable cycles required before the debounced level changes (DB >= 1).
- CW, 8, width of press_count.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- raw_btn  input  1  asynchronous, bouncy button level.
- light  input  1  light status from the light controller (1 = ON).
- push_btn  output  1  one-cycle request pulse to the light controller.
- pending  output  1  a press is waiting for light to go OFF.
- press_count  output  CW  number of accepted debounced presses, saturating.
- no_ack  output  1  sticky protocol error flag (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high) clears: both synchroniser flops, btn_state, btn_prev, the debounce counter, press_count, no_ack. FSM goes to IDLE; push_btn=0, pending=0.
- Synchroniser: two flops, sync0 <= raw_btn, sync1 <= sync0. Not bypassable.
- Debounce:
  - cnt is a ceil(log2(DB+1))-bit counter.
  - If sync1 == btn_state, then cnt <= 0.
  - Otherwise, if cnt == DB-1, then btn_state <= sync1 and cnt <= 0; else cnt <= cnt+1.
  - A glitch shorter than DB cycles of sync1 never changes btn_state.
- Edge detect: btn_prev <= btn_state; press = btn_state & ~btn_prev. Press is combinational and lasts one cycle; release edges are ignored.
- press_count increments on every press, in any FSM state, and saturates at 2^CW-1.
- FSM states are IDLE, WAIT_OFF, FIRE. Outputs are Moore: push_btn = (state==FIRE), pending = (state==WAIT_OFF).
  - IDLE: press & ~light -> FIRE; press & light -> WAIT_OFF; otherwise stay.
  - WAIT_OFF: ~light -> FIRE; otherwise stay. Further presses are counted but not queued; pending depth is 1.
  - FIRE: unconditionally -> IDLE. A press during FIRE is counted and dropped.
- Latency, with raw_btn stable high from edge k (DB=4):
  - sync1 = 1 after edge k+1.
  - btn_state = 1 after edge k+1+DB.
  - push_btn high for exactly the cycle after edge k+2+DB (edge 6 when k=0).
- Simultaneous events: a press in the same cycle that light falls is evaluated by the IDLE rule using the current light value. light=0 gives FIRE.
- Reset mid-operation: the pending request is discarded and any FIRE pulse is cut. Following reset, raw_btn already held high is treated as a new press once debounced.

Optional Feature:
- Macro: PUSH_ACK_CHECK_EN.
- Defined:
  - After every push_btn pulse, light must be 1 in at least one of the two following cycles.
  - If it is not, no_ack <= 1 and stays 1 until reset.
  - A new push_btn inside the check window restarts the window.
- Undefined: no_ack is tied to 0 and no checker logic is generated. The port still exists.

Decomposition:
- Package light_ctrl_pkg:
  - typedef enum logic [1:0] {IDLE, WAIT_OFF, FIRE} drv_state_t;
  - localparam DB_DEFAULT=4, CW_DEFAULT=8.
- Sub-module btn_debounce (parameter DB):
  - Contains the synchroniser, debounce counter and edge detect.
  - Ports: clock, reset, raw_btn, level, press.
- push_btn_driver instantiates btn_debounce and holds the FSM, counter and checker.

Test Plan:
- Clean press, DB=4, light=0: raw_btn 0->1 before edge 0, held -> push_btn=1 only in the cycle after edge 6; press_count=1; pending stays 0.
- Bounce rejection: raw_btn 1 for 3 cycles then 0, repeated 5 times -> push_btn never asserts; press_count=0.
- Pending:
  - Press with light=1 -> pending=1 the cycle after the press is detected.
  - Drop light at cycle 20 -> push_btn=1 the cycle after edge 20; pending=0 from then on.
- Overflow and saturation:
  - Three presses while light=1 -> exactly one push_btn after light falls; press_count=3.
  - CW=2 with 5 presses -> press_count=3.
- Reset mid-WAIT_OFF: assert reset for 1 cycle, then drop light -> no push_btn; pending=0; press_count=0.
- PUSH_ACK_CHECK_EN defined:
  - Hold light=0 after the push_btn pulse -> no_ack=1 two cycles later, and it stays 1.
  - light=1 the cycle after push_btn -> no_ack stays 0.
